ram_port_arbiter: RTL and testbench

- Shares one port of the 512x16 dual-port RAM between two requesters: requester 0 (Avalon host path) and requester 1 (sequence-scan unit).
- Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.
- The block drives the RAM address, write data and write enable from the winning requester.
- It returns read data to the originator with a one-cycle valid strobe, matching the RAM's registered-address read latency.

---
 rtl/ram_port_arbiter_if.sv | 29 ++
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the two RAM requesters, the port arbiter and one RAM port.
// slave = arbiter side, master = requesters + RAM side.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req0, req1;
    logic              lock0, lock1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_wdata, ram_wren
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters, with bounded lock bursts.
// Define ARB_FIXED_PRIO_EN to make requester 0 win every unlocked contention.

// Per-requester read return: valid one cycle after a granted read, data straight from RAM q.
module ram_port_arbiter_rsp #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              gnt,
    input  logic              we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rvalid <= 1'b0;
        else         rvalid <= gnt & ~we;
    end

    assign rdata = ram_q;
endmodule

module ram_port_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 16
) (
    input  logic              clock,
    input  logic              resetn,
    ram_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;

    logic [1:0]             req, lock, we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             gnt_raw, gnt, rvalid;
    logic [1:0][DATA_W-1:0] rdata;

    logic own_valid, own_id, burst_full, force_yield, contend_win;
    logic win, any_gnt;

    assign req   = {bus.req1, bus.req0};
    assign lock  = {bus.lock1, bus.lock0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

`ifdef ARB_FIXED_PRIO_EN
    assign contend_win = 1'b0;
`else
    assign contend_win = ~last_q;
`endif

    // Grant selection: live lock first, forced yield at BURST_MAX, then single/contended request.
    always_comb begin
        own_valid   = (owner_q != OWN_NONE);
        own_id      = (owner_q == OWN_1);
        burst_full  = (burst_q == BURST_MAX_C);
        force_yield = own_valid && req[own_id] && burst_full && req[~own_id];
        gnt_raw     = 2'b00;
        if (force_yield)
            gnt_raw[~own_id] = 1'b1;
        else if (own_valid && req[own_id])
            gnt_raw[own_id] = 1'b1;
        else if (req == 2'b01)
            gnt_raw[0] = 1'b1;
        else if (req == 2'b10)
            gnt_raw[1] = 1'b1;
        else if (req == 2'b11)
            gnt_raw[contend_win] = 1'b1;
    end

    assign gnt     = resetn ? gnt_raw : 2'b00;
    assign any_gnt = |gnt;
    assign win     = gnt[1];

    // Lock/burst bookkeeping; a yielded burst or an idle owner drops the lock.
    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        last_d  = last_q;
        if (any_gnt) begin
            last_d = win;
            if (force_yield || !lock[win]) begin
                owner_d = OWN_NONE;
                burst_d = '0;
            end else begin
                owner_d = win ? OWN_1 : OWN_0;
                if (own_valid && (own_id == win))
                    burst_d = burst_full ? burst_q : burst_q + CNT_W'(1);
                else
                    burst_d = CNT_W'(1);
            end
        end else begin
            owner_d = OWN_NONE;
            burst_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_q <= OWN_NONE;
            burst_q <= '0;
            last_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    // Idle cycles replay the last driven address/data so the RAM pins stay quiet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else if (any_gnt) begin
            addr_hold_q  <= addr[win];
            wdata_hold_q <= wdata[win];
        end
    end

    assign bus.ram_addr  = any_gnt ? addr[win]  : addr_hold_q;
    assign bus.ram_wdata = any_gnt ? wdata[win] : wdata_hold_q;
    assign bus.ram_wren  = any_gnt & we[win];

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        ram_port_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
            .clock  (clock),
            .resetn (resetn),
            .gnt    (gnt[i]),
            .we     (we[i]),
            .ram_q  (bus.ram_q),
            .rvalid (rvalid[i]),
            .rdata  (rdata[i])
        );
    end

    assign bus.gnt0    = gnt[0];
    assign bus.gnt1    = gnt[1];
    assign bus.rvalid0 = rvalid[0];
    assign bus.rvalid1 = rvalid[1];
    assign bus.rdata0  = rdata[0];
    assign bus.rdata1  = rdata[1];
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 512x16 registered-address RAM model.
module tb_ram_port_arbiter;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clock = ~clock;

    ram_port_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(16), .BURST_MAX(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [15:0] mem [0:511];
    logic [8:0]  ram_addr_q;
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        ram_addr_q <= bus.ram_addr;
    end
    assign bus.ram_q = mem[ram_addr_q];

    task automatic idle();
        bus.req0 = 0; bus.lock0 = 0; bus.we0 = 0;
        bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0;
    endtask

    task automatic drive0(input logic r, input logic l, input logic w, input logic [8:0] a, input logic [15:0] d);
        bus.req0 = r; bus.lock0 = l; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic l, input logic w, input logic [8:0] a, input logic [15:0] d);
        bus.req1 = r; bus.lock1 = l; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic test_reset();
        idle();
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        resetn = 1'b0;
        bus.req0 = 1; bus.req1 = 1;
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b0) $display("FAIL rst_gnt0 got %b want 0", bus.gnt0); else pass_cnt++;
        total_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL rst_gnt1 got %b want 0", bus.gnt1); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL rst_rvalid0 got %b want 0", bus.rvalid0); else pass_cnt++;
        total_cnt++; if (bus.rvalid1 !== 1'b0) $display("FAIL rst_rvalid1 got %b want 0", bus.rvalid1); else pass_cnt++;
        total_cnt++; if (bus.ram_wren !== 1'b0) $display("FAIL rst_wren got %b want 0", bus.ram_wren); else pass_cnt++;
        @(negedge clock);
        idle();
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        drive0(1, 0, 1, 9'h005, 16'hBEEF);
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL wr_gnt0 got %b want 1", bus.gnt0); else pass_cnt++;
        total_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL wr_gnt1 got %b want 0", bus.gnt1); else pass_cnt++;
        total_cnt++; if (bus.ram_wren !== 1'b1) $display("FAIL wr_wren got %b want 1", bus.ram_wren); else pass_cnt++;
        total_cnt++; if (bus.ram_addr !== 9'h005) $display("FAIL wr_addr got %h want 005", bus.ram_addr); else pass_cnt++;
        total_cnt++; if (bus.ram_wdata !== 16'hBEEF) $display("FAIL wr_wdata got %h want beef", bus.ram_wdata); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL wr_rvalid0 got %b want 0", bus.rvalid0); else pass_cnt++;
        @(negedge clock);
        idle();
        drive1(1, 0, 0, 9'h005, 16'h0000);
        #1;
        total_cnt++; if (bus.gnt1 !== 1'b1) $display("FAIL rd_gnt1 got %b want 1", bus.gnt1); else pass_cnt++;
        total_cnt++; if (bus.ram_wren !== 1'b0) $display("FAIL rd_wren got %b want 0", bus.ram_wren); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid1 !== 1'b1) $display("FAIL rd_rvalid1 got %b want 1", bus.rvalid1); else pass_cnt++;
        total_cnt++; if (bus.rdata1 !== 16'hBEEF) $display("FAIL rd_rdata1 got %h want beef", bus.rdata1); else pass_cnt++;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL rd_rvalid0 got %b want 0", bus.rvalid0); else pass_cnt++;
        @(negedge clock);
        idle();
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid1 !== 1'b0) $display("FAIL rd_rvalid1_off got %b want 0", bus.rvalid1); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [8:0]  pa [3];
        logic [15:0] pd [3];
        logic [3:0]  exp0;
        pa = '{9'h010, 9'h020, 9'h030};
        pd = '{16'h1111, 16'h2222, 16'h3333};
        exp0 = 4'b0101;
        // Preload through requester 1 so last_grant ends at 1.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive1(1, 0, 1, pa[i], pd[i]);
            #1;
            total_cnt++; if (bus.gnt1 !== 1'b1) $display("FAIL pre_gnt1[%0d] got %b want 1", i, bus.gnt1); else pass_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive0(1, 0, 0, 9'h010, 16'h0);
            drive1(1, 0, 0, 9'h020, 16'h0);
            #1;
            total_cnt++; if (bus.gnt0 !== exp0[k]) $display("FAIL rr_gnt0[%0d] got %b want %b", k, bus.gnt0, exp0[k]); else pass_cnt++;
            total_cnt++; if (bus.gnt1 !== ~exp0[k]) $display("FAIL rr_gnt1[%0d] got %b want %b", k, bus.gnt1, ~exp0[k]); else pass_cnt++;
            @(posedge clock); #1;
            total_cnt++; if (bus.rvalid0 !== exp0[k]) $display("FAIL rr_rvalid0[%0d] got %b want %b", k, bus.rvalid0, exp0[k]); else pass_cnt++;
            total_cnt++; if (bus.rvalid1 !== ~exp0[k]) $display("FAIL rr_rvalid1[%0d] got %b want %b", k, bus.rvalid1, ~exp0[k]); else pass_cnt++;
            if (exp0[k]) begin
                total_cnt++; if (bus.rdata0 !== 16'h1111) $display("FAIL rr_rdata0[%0d] got %h want 1111", k, bus.rdata0); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.rdata1 !== 16'h2222) $display("FAIL rr_rdata1[%0d] got %h want 2222", k, bus.rdata1); else pass_cnt++;
            end
        end
        @(negedge clock);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [8:0]  ra [3];
        logic [15:0] rd [3];
        ra = '{9'h030, 9'h010, 9'h020};
        rd = '{16'h3333, 16'h1111, 16'h2222};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive0(1, 0, 0, ra[i], 16'h0);
            @(posedge clock); #1;
            total_cnt++; if (bus.rvalid0 !== 1'b1) $display("FAIL b2b_rvalid0[%0d] got %b want 1", i, bus.rvalid0); else pass_cnt++;
            total_cnt++; if (bus.rdata0 !== rd[i]) $display("FAIL b2b_rdata0[%0d] got %h want %h", i, bus.rdata0, rd[i]); else pass_cnt++;
        end
        @(negedge clock);
        idle();
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL b2b_rvalid0_off got %b want 0", bus.rvalid0); else pass_cnt++;
    endtask

    task automatic test_burst();
        logic e1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            drive1(1, 1, 0, 9'h030, 16'h0);
            drive0(c >= 3, 0, 0, 9'h010, 16'h0);
            #1;
            e1 = (c < 16) || (c >= 17);
            total_cnt++; if (bus.gnt1 !== e1) $display("FAIL burst_gnt1[%0d] got %b want %b", c, bus.gnt1, e1); else pass_cnt++;
            total_cnt++; if (bus.gnt0 !== ~e1) $display("FAIL burst_gnt0[%0d] got %b want %b", c, bus.gnt0, ~e1); else pass_cnt++;
        end
        @(negedge clock);
        drive1(0, 0, 0, 9'h030, 16'h0);
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL burst_tail_gnt0 got %b want 1", bus.gnt0); else pass_cnt++;
        @(negedge clock);
        idle();
    endtask

    task automatic test_lock_release();
        @(negedge clock);
        drive1(1, 1, 0, 9'h0AB, 16'h0);
        #1;
        total_cnt++; if (bus.gnt1 !== 1'b1) $display("FAIL lr_gnt1 got %b want 1", bus.gnt1); else pass_cnt++;
        @(negedge clock);
        drive1(0, 1, 0, 9'h1FF, 16'h0);
        #1;
        total_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL lr_idle_gnt1 got %b want 0", bus.gnt1); else pass_cnt++;
        total_cnt++; if (bus.ram_wren !== 1'b0) $display("FAIL lr_idle_wren got %b want 0", bus.ram_wren); else pass_cnt++;
        total_cnt++; if (bus.ram_addr !== 9'h0AB) $display("FAIL lr_hold_addr got %h want 0ab", bus.ram_addr); else pass_cnt++;
        @(negedge clock);
        drive0(1, 0, 0, 9'h010, 16'h0);
        drive1(1, 0, 0, 9'h020, 16'h0);
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL lr_gnt0 got %b want 1", bus.gnt0); else pass_cnt++;
        total_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL lr_gnt1_after got %b want 0", bus.gnt1); else pass_cnt++;
        @(negedge clock);
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        drive0(1, 0, 0, 9'h010, 16'h0);
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL mr_gnt0_pre got %b want 1", bus.gnt0); else pass_cnt++;
        #1 resetn = 1'b0;
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b0) $display("FAIL mr_gnt0_rst got %b want 0", bus.gnt0); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL mr_rvalid0 got %b want 0", bus.rvalid0); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL mr_rvalid0_2 got %b want 0", bus.rvalid0); else pass_cnt++;
        @(negedge clock);
        resetn = 1'b1;
        drive0(1, 0, 0, 9'h010, 16'h0);
        drive1(1, 0, 0, 9'h020, 16'h0);
        #1;
        total_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL mr_post_gnt0 got %b want 1", bus.gnt0); else pass_cnt++;
        total_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL mr_post_gnt1 got %b want 0", bus.gnt1); else pass_cnt++;
        @(negedge clock);
        idle();
    endtask

    task automatic test_contention5();
        logic [4:0] exp0;
`ifdef ARB_FIXED_PRIO_EN
        exp0 = 5'b11111;
`else
        exp0 = 5'b01010;
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            drive0(1, 0, 0, 9'h010, 16'h0);
            drive1(1, 0, 0, 9'h020, 16'h0);
            #1;
            total_cnt++; if (bus.gnt0 !== exp0[k]) $display("FAIL c5_gnt0[%0d] got %b want %b", k, bus.gnt0, exp0[k]); else pass_cnt++;
            total_cnt++; if (bus.gnt1 !== ~exp0[k]) $display("FAIL c5_gnt1[%0d] got %b want %b", k, bus.gnt1, ~exp0[k]); else pass_cnt++;
        end
        @(negedge clock);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_burst();
        test_lock_release();
        test_reset_mid();
        test_contention5();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
